seq_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 39 +++
 rtl/seq_alu_if.sv | 32 +++
 rtl/alu_core.sv | 101 ++++++++++
 rtl/seq_alu.sv | 146 ++++++++++++++
 tb/tb_seq_alu.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: op encodings, FSM states
// and the bit positions of the Z/S/C/V status flags.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOT  = 4'd0,
        OP_AND  = 4'd1,
        OP_OR   = 4'd2,
        OP_XOR  = 4'd3,
        OP_ADD  = 4'd4,
        OP_ADC  = 4'd5,
        OP_SUB  = 4'd6,
        OP_SBC  = 4'd7,
        OP_INC  = 4'd8,
        OP_DEC  = 4'd9,
        OP_SHL  = 4'd10,
        OP_SHR  = 4'd11,
        OP_ROL  = 4'd12,
        OP_ROR  = 4'd13,
        OP_CMP  = 4'd14,
        OP_PASS = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_S = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    function automatic logic is_shift(input op_e op);
        return op inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR};
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between the datapath (master) and seq_alu (slave).
interface seq_alu_if #(
    parameter int unsigned WORD_W  = 20,
    parameter int unsigned SHAMT_W = $clog2(WORD_W) + 1
);
    import alu_pkg::*;

    logic               in_valid;
    logic               in_ready;
    op_e                op;
    logic               mode;
    logic [WORD_W-1:0]  a;
    logic [WORD_W-1:0]  b;
    logic [SHAMT_W-1:0] shamt;
    logic               flag_load;
    logic [3:0]         flag_in;
    logic               out_valid;
    logic               out_ready;
    logic [WORD_W-1:0]  result;
    logic [3:0]         flags;

    modport master (
        output in_valid, op, mode, a, b, shamt, flag_load, flag_in, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, mode, a, b, shamt, flag_load, flag_in, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU step: full single-cycle ops, or one bit of a shift/rotate,
// at active width WORD_W or HALF_W. Produces the next result and next flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WORD_W = 20,
    parameter int unsigned HALF_W = WORD_W / 2
) (
    input  op_e               i_op,
    input  logic              i_mode,
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_cin,
    input  logic [3:0]        i_flags,
    input  logic              i_shift_en,
    output logic [WORD_W-1:0] o_result,
    output logic [3:0]        o_flags
);

    localparam logic [WORD_W-1:0] ONE = {{(WORD_W-1){1'b0}}, 1'b1};

    logic [WORD_W-1:0] w_mask;
    logic [WORD_W-1:0] w_top;
    logic [WORD_W-1:0] w_a;
    logic [WORD_W-1:0] w_b;
    logic [WORD_W-1:0] w_opb;
    logic [WORD_W-1:0] w_res;
    logic [WORD_W-1:0] w_zs;
    logic [WORD_W:0]   w_ext;
    logic              w_ci;
    logic              w_out;
    logic [3:0]        w_flg;

    function automatic logic msb(input logic [WORD_W-1:0] v, input logic m);
        return m ? v[WORD_W-1] : v[HALF_W-1];
    endfunction

    assign w_mask = i_mode ? '1 : {{(WORD_W-HALF_W){1'b0}}, {HALF_W{1'b1}}};
    assign w_top  = w_mask & ~(w_mask >> 1);
    assign w_a    = i_a & w_mask;
    assign w_b    = i_b & w_mask;

    always_comb begin
        w_res = w_a;
        w_zs  = w_a;
        w_opb = w_b;
        w_ci  = 1'b0;
        w_ext = '0;
        w_out = 1'b0;
        w_flg = i_flags;
        case (i_op)
            OP_NOT: w_res = ~w_a & w_mask;
            OP_AND: w_res = w_a & w_b;
            OP_OR:  w_res = w_a | w_b;
            OP_XOR: w_res = w_a ^ w_b;
            OP_ADD, OP_ADC, OP_INC: begin
                if (i_op == OP_INC) w_opb = ONE;
                w_ci  = (i_op == OP_ADC) ? i_cin : 1'b0;
                w_ext = {1'b0, w_a} + {1'b0, w_opb} + {{WORD_W{1'b0}}, w_ci};
                w_res = w_ext[WORD_W-1:0] & w_mask;
                w_flg[FLAG_C] = i_mode ? w_ext[WORD_W] : w_ext[HALF_W];
                w_flg[FLAG_V] = (msb(w_a, i_mode) == msb(w_opb, i_mode)) &&
                                (msb(w_res, i_mode) != msb(w_a, i_mode));
            end
            OP_SUB, OP_SBC, OP_DEC, OP_CMP: begin
                if (i_op == OP_DEC) w_opb = ONE;
                w_ci  = (i_op == OP_SBC) ? i_cin : 1'b0;
                // Wraps negative in WORD_W+1 bits, so bit W is the borrow.
                w_ext = {1'b0, w_a} - {1'b0, w_opb} - {{WORD_W{1'b0}}, w_ci};
                w_res = w_ext[WORD_W-1:0] & w_mask;
                w_flg[FLAG_C] = i_mode ? w_ext[WORD_W] : w_ext[HALF_W];
                w_flg[FLAG_V] = (msb(w_a, i_mode) != msb(w_opb, i_mode)) &&
                                (msb(w_res, i_mode) != msb(w_a, i_mode));
                if (i_op == OP_CMP) begin
                    w_zs  = w_res;
                    w_res = w_a;
                end
            end
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                if (i_shift_en) begin
                    if (i_op == OP_SHL || i_op == OP_ROL) begin
                        w_out = msb(w_a, i_mode);
                        w_res = ((w_a << 1) | ((i_op == OP_ROL && w_out) ? ONE : '0)) & w_mask;
                    end else begin
                        w_out = w_a[0];
                        w_res = (w_a >> 1) | ((i_op == OP_ROR && w_out) ? w_top : '0);
                    end
                    w_flg[FLAG_C] = w_out;
                end
            end
            default: ;
        endcase
        if (i_op != OP_CMP) w_zs = w_res;
        w_flg[FLAG_Z] = (w_zs == '0);
        w_flg[FLAG_S] = msb(w_zs, i_mode);
    end

    assign o_result = w_res;
    assign o_flags  = w_flg;

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: accepts operands in IDLE, iterates variable shifts
// one bit per clock in SHIFT, and holds result/status in DONE until consumed.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WORD_W  = 20,
    parameter int unsigned HALF_W  = WORD_W / 2,
    parameter int unsigned SHAMT_W = $clog2(WORD_W) + 1
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_alu_if.slave  bus
);

    state_e             r_state;
    state_e             w_next;
    op_e                r_op;
    logic               r_mode;
    logic [WORD_W-1:0]  r_a;
    logic [WORD_W-1:0]  r_b;
    logic               r_cin;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WORD_W-1:0]  r_result;
    logic [3:0]         r_flags;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    op_e                w_c_op;
    logic               w_c_mode;
    logic [WORD_W-1:0]  w_c_a;
    logic [WORD_W-1:0]  w_c_b;
    logic               w_c_cin;
    logic               w_c_shift;
    logic [WORD_W-1:0]  w_res;
    logic [3:0]         w_flg;

    assign w_accept = (r_state == IDLE) && bus.in_valid && !bus.flag_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = !bus.flag_load;
                if (w_accept)
                    w_next = (is_shift(bus.op) && bus.shamt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                if (r_cnt <= SHAMT_W'(1)) w_next = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Single-cycle ops complete on the accept edge, so the core sees the bus directly in IDLE.
    always_comb begin
        if (r_state == IDLE) begin
            w_c_op    = bus.op;
            w_c_mode  = bus.mode;
            w_c_a     = bus.a;
            w_c_b     = bus.b;
            w_c_cin   = r_flags[FLAG_C];
            w_c_shift = 1'b0;
        end else begin
            w_c_op    = r_op;
            w_c_mode  = r_mode;
            w_c_a     = r_a;
            w_c_b     = r_b;
            w_c_cin   = r_cin;
            w_c_shift = (r_state == SHIFT);
        end
    end

    alu_core #(
        .WORD_W (WORD_W),
        .HALF_W (HALF_W)
    ) u_core (
        .i_op       (w_c_op),
        .i_mode     (w_c_mode),
        .i_a        (w_c_a),
        .i_b        (w_c_b),
        .i_cin      (w_c_cin),
        .i_flags    (r_flags),
        .i_shift_en (w_c_shift),
        .o_result   (w_res),
        .o_flags    (w_flg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_NOT;
            r_mode   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.flag_load) begin
                        r_flags <= bus.flag_in;
                    end else if (bus.in_valid) begin
                        r_op   <= bus.op;
                        r_mode <= bus.mode;
                        r_a    <= bus.a;
                        r_b    <= bus.b;
                        r_cin  <= r_flags[FLAG_C];
                        r_cnt  <= bus.shamt;
                        if (w_next == DONE) begin
                            r_result <= w_res;
                            r_flags  <= w_flg;
                        end
                    end
                end
                SHIFT: begin
                    r_a   <= w_res;
                    r_cnt <= r_cnt - SHAMT_W'(1);
                    if (w_next == DONE) begin
                        r_result <= w_res;
                        r_flags  <= w_flg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int unsigned WW = 20;
    localparam int unsigned SW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.WORD_W(WW), .SHAMT_W(SW)) bus();

    seq_alu #(.WORD_W(WW), .HALF_W(WW/2), .SHAMT_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] m_flags;

    function automatic longint sg(input longint x, input longint w);
        return (x >= (longint'(1) << (w-1))) ? x - (longint'(1) << w) : x;
    endfunction

    // Returns {result[19:0], V, C, S, Z} from plain integer arithmetic.
    function automatic logic [23:0] ref_op(input op_e op, input logic mode,
                                           input logic [19:0] a, input logic [19:0] b,
                                           input int unsigned sh, input logic [3:0] fl);
        longint w, m, h, av, bv, bb, ci, r, zs, t, st;
        logic c, v, z, s;
        logic [19:0] rr;
        w = mode ? 20 : 10;
        m = (longint'(1) << w) - 1;
        h = longint'(1) << (w-1);
        av = longint'(a) & m;
        bv = longint'(b) & m;
        r = av; zs = av; c = fl[2]; v = fl[3];
        case (op)
            OP_NOT: r = (~av) & m;
            OP_AND: r = av & bv;
            OP_OR:  r = av | bv;
            OP_XOR: r = av ^ bv;
            OP_ADD, OP_ADC, OP_INC: begin
                bb = (op == OP_INC) ? 1 : bv;
                ci = (op == OP_ADC) ? longint'(fl[2]) : 0;
                t = av + bb + ci;
                r = t & m;
                c = (t > m);
                st = sg(av, w) + sg(bb, w) + ci;
                v = (st >= h) || (st < -h);
            end
            OP_SUB, OP_SBC, OP_DEC, OP_CMP: begin
                bb = (op == OP_DEC) ? 1 : bv;
                ci = (op == OP_SBC) ? longint'(fl[2]) : 0;
                t = av - bb - ci;
                r = t & m;
                c = (t < 0);
                st = sg(av, w) - sg(bb, w) - ci;
                v = (st >= h) || (st < -h);
            end
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                for (int unsigned i = 0; i < sh; i++) begin
                    if (op == OP_SHL || op == OP_ROL) begin
                        c = ((r >> (w-1)) & 1) != 0;
                        r = ((r << 1) & m) | ((op == OP_ROL && c) ? 1 : 0);
                    end else begin
                        c = (r & 1) != 0;
                        r = (r >> 1) | ((op == OP_ROR && c) ? h : 0);
                    end
                end
            end
            default: ;
        endcase
        zs = r;
        if (op == OP_CMP) begin
            zs = r;
            r = av;
        end
        z = (zs == 0);
        s = ((zs >> (w-1)) & 1) != 0;
        rr = r[19:0];
        return {rr, v, c, s, z};
    endfunction

    task automatic run_op(input op_e op, input logic mode, input logic [19:0] a,
                          input logic [19:0] b, input logic [5:0] sh, output int lat);
        bus.op = op; bus.mode = mode; bus.a = a; bus.b = b; bus.shamt = sh;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic leave_done();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.out_ready = 1; bus.flag_load = 0; bus.flag_in = 0;
        bus.op = OP_NOT; bus.mode = 1; bus.a = 0; bus.b = 0; bus.shamt = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.flags !== 4'h0) begin n_bad++; $display("FAIL reset_flags: got %h want 0", bus.flags); end
        n_cmp++; if (bus.result !== 20'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.result); end
        rst_n = 1;
        @(posedge clk); #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        m_flags = 4'h0;
    endtask

    task automatic test_add_full();
        int lat;
        logic [23:0] e;
        e = ref_op(OP_ADD, 1, 20'hFFFFF, 20'h00001, 0, m_flags);
        run_op(OP_ADD, 1, 20'hFFFFF, 20'h00001, 0, lat);
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL add_full_latency: got %0d want 1", lat); end
        n_cmp++; if (bus.result !== 20'h00000 || e[23:4] !== 20'h00000) begin n_bad++; $display("FAIL add_full_result: got %h want 00000", bus.result); end
        n_cmp++; if (bus.flags !== 4'b0101 || e[3:0] !== 4'b0101) begin n_bad++; $display("FAIL add_full_flags: got %b want 0101", bus.flags); end
        m_flags = e[3:0];
        leave_done();
    endtask

    task automatic test_add_half_adc();
        int lat;
        logic [23:0] e;
        e = ref_op(OP_ADD, 0, 20'hAB3FF, 20'h00001, 0, m_flags);
        run_op(OP_ADD, 0, 20'hAB3FF, 20'h00001, 0, lat);
        n_cmp++; if (bus.result !== 20'h00000) begin n_bad++; $display("FAIL add_half_result: got %h want 00000", bus.result); end
        n_cmp++; if (bus.flags[FLAG_Z] !== 1'b1 || bus.flags[FLAG_C] !== 1'b1 || bus.flags !== e[3:0]) begin n_bad++; $display("FAIL add_half_flags: got %b want %b", bus.flags, e[3:0]); end
        m_flags = e[3:0];
        leave_done();
        e = ref_op(OP_ADC, 0, 20'h00001, 20'h00001, 0, m_flags);
        run_op(OP_ADC, 0, 20'h00001, 20'h00001, 0, lat);
        n_cmp++; if (bus.result !== 20'h00003 || e[23:4] !== 20'h00003) begin n_bad++; $display("FAIL adc_result: got %h want 00003", bus.result); end
        n_cmp++; if (bus.flags[FLAG_C] !== 1'b0 || bus.flags !== e[3:0]) begin n_bad++; $display("FAIL adc_flags: got %b want %b", bus.flags, e[3:0]); end
        m_flags = e[3:0];
        leave_done();
    endtask

    task automatic test_sub_cmp();
        int lat;
        run_op(OP_SUB, 1, 20'd5, 20'd7, 0, lat);
        n_cmp++; if (bus.result !== 20'hFFFFE) begin n_bad++; $display("FAIL sub_result: got %h want FFFFE", bus.result); end
        n_cmp++; if (bus.flags !== 4'b0110) begin n_bad++; $display("FAIL sub_flags: got %b want 0110", bus.flags); end
        leave_done();
        run_op(OP_CMP, 1, 20'd7, 20'd7, 0, lat);
        n_cmp++; if (bus.result !== 20'h00007) begin n_bad++; $display("FAIL cmp_result: got %h want 00007", bus.result); end
        n_cmp++; if (bus.flags !== 4'b0001) begin n_bad++; $display("FAIL cmp_flags: got %b want 0001", bus.flags); end
        m_flags = 4'b0001;
        leave_done();
    endtask

    task automatic test_rol();
        int lat;
        run_op(OP_ROL, 1, 20'h80001, 20'h0, 6'd3, lat);
        n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL rol3_latency: got %0d want 4", lat); end
        n_cmp++; if (bus.result !== 20'h0000C) begin n_bad++; $display("FAIL rol3_result: got %h want 0000C", bus.result); end
        n_cmp++; if (bus.flags !== 4'b0000) begin n_bad++; $display("FAIL rol3_flags: got %b want 0000", bus.flags); end
        leave_done();
        run_op(OP_ROL, 1, 20'h80001, 20'h0, 6'd0, lat);
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL rol0_latency: got %0d want 1", lat); end
        n_cmp++; if (bus.result !== 20'h80001) begin n_bad++; $display("FAIL rol0_result: got %h want 80001", bus.result); end
        n_cmp++; if (bus.flags !== 4'b0010) begin n_bad++; $display("FAIL rol0_flags: got %b want 0010", bus.flags); end
        m_flags = 4'b0010;
        leave_done();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [23:0] e1, e2;
        logic [19:0] a1, b1, a2, b2;
        a1 = 20'($urandom); b1 = 20'($urandom); a2 = 20'($urandom); b2 = 20'($urandom);
        e1 = ref_op(OP_ADD, 1, a1, b1, 0, m_flags);
        e2 = ref_op(OP_XOR, 1, a2, b2, 0, e1[3:0]);
        bus.out_ready = 0;
        run_op(OP_ADD, 1, a1, b1, 0, lat);
        bus.op = OP_XOR; bus.a = a2; bus.b = b2; bus.in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== e1[23:4] || bus.flags !== e1[3:0]) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got v=%b r=%b res=%h fl=%b want v=1 r=0 res=%h fl=%b", i, bus.out_valid, bus.in_ready, bus.result, bus.flags, e1[23:4], e1[3:0]);
            end
        end
        bus.out_ready = 1;
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.result !== e2[23:4] || bus.flags !== e2[3:0]) begin n_bad++; $display("FAIL bp_second: got v=%b res=%h fl=%b want v=1 res=%h fl=%b", bus.out_valid, bus.result, bus.flags, e2[23:4], e2[3:0]); end
        m_flags = e2[3:0];
        leave_done();
    endtask

    task automatic test_reset_flagload();
        bus.op = OP_SHR; bus.mode = 1; bus.a = 20'($urandom); bus.shamt = 6'd15; bus.in_valid = 1;
        @(posedge clk); #1;
        bus.in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.flags !== 4'h0 || bus.result !== 20'h0) begin n_bad++; $display("FAIL midreset: got v=%b fl=%b res=%h want 0 0 0", bus.out_valid, bus.flags, bus.result); end
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_release: got r=%b v=%b want r=1 v=0", bus.in_ready, bus.out_valid); end
        bus.flag_load = 1; bus.flag_in = 4'b0100; bus.in_valid = 1;
        bus.op = OP_ADD; bus.a = 20'd1; bus.b = 20'd1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flagload_ready: got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        bus.flag_load = 0; bus.in_valid = 0;
        n_cmp++; if (bus.flags !== 4'h4 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flagload: got fl=%h v=%b want fl=4 v=0", bus.flags, bus.out_valid); end
        m_flags = 4'h4;
    endtask

    task automatic test_random();
        int lat, elat;
        op_e op;
        logic md;
        logic [19:0] a, b;
        logic [5:0] sh;
        logic [23:0] e;
        for (int i = 0; i < 60; i++) begin
            op = op_e'($urandom_range(0, 15));
            md = 1'($urandom);
            a = 20'($urandom); b = 20'($urandom);
            sh = is_shift(op) ? 6'($urandom_range(0, 25)) : 6'($urandom_range(0, 63));
            e = ref_op(op, md, a, b, is_shift(op) ? int'(sh) : 0, m_flags);
            elat = (is_shift(op) && sh != 0) ? int'(sh) + 1 : 1;
            run_op(op, md, a, b, sh, lat);
            n_cmp++; if (lat != elat || bus.result !== e[23:4] || bus.flags !== e[3:0]) begin
                n_bad++; $display("FAIL rand[%0d] op=%0d m=%b a=%h b=%h sh=%0d: got lat=%0d res=%h fl=%b want lat=%0d res=%h fl=%b", i, op, md, a, b, sh, lat, bus.result, bus.flags, elat, e[23:4], e[3:0]);
            end
            m_flags = e[3:0];
            leave_done();
        end
    endtask

    initial begin
        test_reset();
        test_add_full();
        test_add_half_adc();
        test_sub_cmp();
        test_rol();
        test_backpressure();
        test_reset_flagload();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
